sm83_irq_ctl: RTL and testbench
===============================

# sm83_irq_ctl

Interrupt controller on the far side of the CPU core's `irq`/`iack` interface and a memory-mapped responder on its data bus. Holds the interrupt flag register IF (0xFF0F) and the interrupt enable register IE (0xFFFF). Latches peripheral request edges into IF and presents `IF & IE` to the core as `irq`. Clears IF bits when the core acknowledges them on `iack`.

## Interface
Parameters:
- `NUM_IRQS`, default 5: number of implemented IF sources. Valid range 1..8. IF bits at and above `NUM_IRQS` are unimplemented.
- `ADR_IF`, default 16'hff0f: IF register address.
- `ADR_IE`, default 16'hffff: IE register address.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `adr` in 16: CPU address bus.
- `din` in 8: CPU write data (core `dout`).
- `dout` out 8: read data to the core.
- `dout_oe` out 1: read data valid / bus drive enable.
- `rd` in 1: active-high read strobe.
- `wr` in 1: active-high write strobe.
- `req` in NUM_IRQS: peripheral request levels; a rising edge raises the request.
- `irq` out 8: pending and enabled interrupts to the core. Bits at and above `NUM_IRQS` are 0.
- `iack` in 8: one-hot acknowledge from the core. Bits at and above `NUM_IRQS` are ignored.

## Operation
- State:
  - `if_q[NUM_IRQS-1:0]`
  - `ie_q[7:0]`
  - `req_d[NUM_IRQS-1:0]` (previous `req`, for edge detection)
  - `wr_d` (previous `wr`)
- Select decode:
  - `sel_if = (adr == ADR_IF)`
  - `sel_ie = (adr == ADR_IE)`
- Write commit: exactly once per strobe, in the cycle where `wr & !wr_d`. `din` is sampled in that cycle. Holding `wr` high for further cycles has no further effect.
- Per-bit next state of `if_q[i]`, highest priority first:
  1. `req[i] & !req_d[i]` (set event) → 1.
  2. `iack[i]` → 0.
  3. Write commit with `sel_if` → `din[i]`.
  4. Otherwise hold.
- `ie_q` loads all 8 bits of `din` on a write commit with `sel_ie`; otherwise it holds. IE is not affected by events or `iack`.
- Read data:
  - IF reads `{ {(8-NUM_IRQS){1'b1}}, if_q }`; unimplemented bits read 1.
  - IE reads `ie_q`.
  - Any other address: `dout_oe` = 0, `dout` = 8'hff.
- `irq = {zero-extended} if_q & ie_q[NUM_IRQS-1:0]`, driven combinationally from flops only.
- `iack` with multiple bits set is illegal input; each set bit still clears its own IF bit.
- Writing IF=1 for a bit with IE=1 raises `irq` exactly as a peripheral event does (software-triggered interrupt).

## Timing
- Reset values (all synchronous):
  - `if_q` = 0, `ie_q` = 0, `req_d` = 0, `wr_d` = 0
  - `dout` = 8'hff, `dout_oe` = 0, `irq` = 0
- Because `req_d` resets to 0, a `req` line that is high when `reset` releases is seen as a rising edge in the first cycle after reset.
- Event to `irq`: a `req` rising edge sampled at edge N sets `if_q` at edge N; `irq` is visible after edge N (1-cycle latency).
- `iack` asserted at edge N: the `irq` bit drops after edge N.
- Write latency: the register updates at the commit edge; `irq` reflects it in the following cycle.
- Read latency: `dout`/`dout_oe` are registered from `rd & sel` and the register value at edge N, so data is valid after edge N. The value returned is the pre-update value when a same-cycle event or write occurs.
- Simultaneous cases:
  - event + `iack` on the same bit → bit stays 1.
  - event + IF write of 0 → bit is 1.
  - `iack` + IF write of 1 → bit is 0.
- Reset mid-strobe: state clears. If `wr` is still high after reset, it is treated as a new rising edge (because `wr_d` resets to 0), and the write commits.

## Test plan
- Reset values: hold reset 2 cycles, then read 0xFF0F → 8'he0, read 0xFFFF → 8'h00; `irq` = 0.
- Enable and raise: write IE=8'h05; pulse `req[2]` for 1 cycle → IF reads 8'he4 and `irq` = 8'h04 one cycle after the edge. Pulse `req[0]` → `irq` = 8'h05.
- Acknowledge: with IF=8'h05, assert `iack`=8'h01 for 1 cycle → IF reads 8'he4, `irq` = 8'h04.
- Collision: in the same cycle, apply a `req[1]` rising edge, `iack[1]`, and a write of IF=8'h00 → IF bit 1 = 1.
- Write once per strobe: hold `wr` high 4 cycles at 0xFF0F with `din`=8'h00, and pulse `req[3]` in strobe cycle 2 → bit 3 remains set after the strobe ends.
- Level versus edge and decode: hold `req[4]` high 10 cycles, clear it via `iack[4]` → IF bit 4 stays 0 while `req[4]` remains high. Read 0xFF10 → `dout_oe` = 0, `dout` = 8'hff.

Source files
------------

// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl: IF/IE interrupt registers with edge-latched requests,
// core acknowledge clearing, and a registered memory-mapped read port.
module sm83_irq_ctl #(
  parameter int          NUM_IRQS = 5,
  parameter logic [15:0] ADR_IF   = 16'hff0f,
  parameter logic [15:0] ADR_IE   = 16'hffff
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         adr,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                dout_oe,
  input  logic                rd,
  input  logic                wr,
  input  logic [NUM_IRQS-1:0] req,
  output logic [7:0]          irq,
  input  logic [7:0]          iack
);

  logic [NUM_IRQS-1:0] if_q;
  logic [7:0]          ie_q;
  logic [NUM_IRQS-1:0] req_d;
  logic                wr_d;

  logic                sel_if;
  logic                sel_ie;
  logic                commit;
  logic [NUM_IRQS-1:0] rise;
  logic [7:0]          if_rd;
  logic [7:0]          imask;
  logic                unused_iack;

  assign sel_if = (adr == ADR_IF);
  assign sel_ie = (adr == ADR_IE);
  assign commit = wr & ~wr_d;
  assign rise   = req & ~req_d;

  // IF read image and irq vector; unimplemented bits read 1 / drive 0
  always_comb begin
    if_rd = 8'hff;
    if_rd[NUM_IRQS-1:0] = if_q;
    irq = 8'h00;
    irq[NUM_IRQS-1:0] = if_q & ie_q[NUM_IRQS-1:0];
    imask = 8'h00;
    imask[NUM_IRQS-1:0] = '1;
  end

  // acknowledge bits beyond the implemented sources have no effect
  assign unused_iack = ^(iack & ~imask);

  // register state, edge detection and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q    <= '0;
      ie_q    <= 8'h00;
      req_d   <= '0;
      wr_d    <= 1'b0;
      dout    <= 8'hff;
      dout_oe <= 1'b0;
    end else begin
      req_d <= req;
      wr_d  <= wr;
      for (int i = 0; i < NUM_IRQS; i++) begin
        if (rise[i])
          if_q[i] <= 1'b1;
        else if (iack[i])
          if_q[i] <= 1'b0;
        else if (commit && sel_if)
          if_q[i] <= din[i];
      end
      if (commit && sel_ie)
        ie_q <= din;
      if (rd && sel_if) begin
        dout    <= if_rd;
        dout_oe <= 1'b1;
      end else if (rd && sel_ie) begin
        dout    <= ie_q;
        dout_oe <= 1'b1;
      end else begin
        dout    <= 8'hff;
        dout_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// tb_sm83_irq_ctl: vector table, hand sequences and random traffic
// checked against a behavioural model of the IF/IE registers.
module tb_sm83_irq_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        rd;
  logic        wr;
  logic [4:0]  req;
  logic [7:0]  irq;
  logic [7:0]  iack;

  int nvec = 0;
  int nerr = 0;

  sm83_irq_ctl #(.NUM_IRQS(5)) dut (
    .clk(clk), .reset(reset), .adr(adr), .din(din),
    .dout(dout), .dout_oe(dout_oe), .rd(rd), .wr(wr),
    .req(req), .irq(irq), .iack(iack)
  );

  always #5 clk = ~clk;

  // model state
  logic [4:0] m_if, m_reqd;
  logic [7:0] m_ie, m_dout;
  logic       m_wrd, m_oe;

  typedef struct {
    logic [15:0] adr;
    logic [7:0]  din;
    logic        rd, wr;
    logic [4:0]  req;
    logic [7:0]  iack;
    logic [7:0]  e_dout;
    logic        e_oe;
    logic [7:0]  e_irq;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_if = 0; m_reqd = 0; m_ie = 0; m_wrd = 0;
    m_dout = 8'hff; m_oe = 0;
  endtask

  task automatic model_step();
    bit commit;
    logic [4:0] set;
    commit = wr && !m_wrd;
    set = req & ~m_reqd;
    if (rd && adr == 16'hff0f) begin
      m_dout = {3'b111, m_if}; m_oe = 1;
    end else if (rd && adr == 16'hffff) begin
      m_dout = m_ie; m_oe = 1;
    end else begin
      m_dout = 8'hff; m_oe = 0;
    end
    for (int i = 0; i < 5; i++) begin
      if (set[i]) m_if[i] = 1'b1;
      else if (iack[i]) m_if[i] = 1'b0;
      else if (commit && adr == 16'hff0f) m_if[i] = din[i];
    end
    if (commit && adr == 16'hffff) m_ie = din;
    m_reqd = req;
    m_wrd = wr;
  endtask

  // one clock with the given inputs, compared against the model
  task automatic apply(input logic [15:0] a, input logic [7:0] d,
                       input logic r, input logic w,
                       input logic [4:0] rq, input logic [7:0] ak);
    adr = a; din = d; rd = r; wr = w; req = rq; iack = ak;
    @(posedge clk);
    model_step();
    #1;
    check("model_dout", dout, m_dout);
    check("model_oe", {7'b0, dout_oe}, {7'b0, m_oe});
    check("model_irq", irq, {3'b000, m_if & m_ie[4:0]});
  endtask

  initial begin
    tv[0]  = '{16'hff0f, 8'h00, 1, 0, 5'h00, 8'h00, 8'he0, 1, 8'h00};
    tv[1]  = '{16'hffff, 8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 1, 8'h00};
    tv[2]  = '{16'hffff, 8'h05, 0, 1, 5'h00, 8'h00, 8'hff, 0, 8'h00};
    tv[3]  = '{16'h0000, 8'h00, 0, 0, 5'h04, 8'h00, 8'hff, 0, 8'h04};
    tv[4]  = '{16'hff0f, 8'h00, 1, 0, 5'h00, 8'h00, 8'he4, 1, 8'h04};
    tv[5]  = '{16'h0000, 8'h00, 0, 0, 5'h01, 8'h00, 8'hff, 0, 8'h05};
    tv[6]  = '{16'hff0f, 8'h00, 1, 0, 5'h00, 8'h00, 8'he5, 1, 8'h05};
    tv[7]  = '{16'h0000, 8'h00, 0, 0, 5'h00, 8'h01, 8'hff, 0, 8'h04};
    tv[8]  = '{16'hff0f, 8'h00, 1, 0, 5'h00, 8'h00, 8'he4, 1, 8'h04};
    tv[9]  = '{16'hff0f, 8'h00, 0, 1, 5'h02, 8'h02, 8'hff, 0, 8'h00};
    tv[10] = '{16'hff0f, 8'h00, 1, 0, 5'h00, 8'h00, 8'he2, 1, 8'h00};

    adr = 0; din = 0; rd = 0; wr = 0; req = 0; iack = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 0;
    check("rst_dout", dout, 8'hff);
    check("rst_oe", {7'b0, dout_oe}, 8'h00);
    check("rst_irq", irq, 8'h00);

    foreach (tv[k]) begin
      apply(tv[k].adr, tv[k].din, tv[k].rd, tv[k].wr, tv[k].req, tv[k].iack);
      check($sformatf("tv%0d_dout", k), dout, tv[k].e_dout);
      check($sformatf("tv%0d_oe", k), {7'b0, dout_oe}, {7'b0, tv[k].e_oe});
      check($sformatf("tv%0d_irq", k), irq, tv[k].e_irq);
    end

    // write commits once per strobe; event mid-strobe survives
    apply(16'hff0f, 8'h00, 0, 1, 5'h00, 8'h00);
    apply(16'hff0f, 8'h00, 0, 1, 5'h08, 8'h00);
    apply(16'hff0f, 8'h00, 0, 1, 5'h00, 8'h00);
    apply(16'hff0f, 8'h00, 0, 1, 5'h00, 8'h00);
    apply(16'hff0f, 8'h00, 1, 0, 5'h00, 8'h00);
    check("strobe_once_if", dout, 8'he8);
    apply(16'hffff, 8'hff, 0, 1, 5'h00, 8'h00);
    apply(16'h0000, 8'h00, 0, 0, 5'h00, 8'h00);
    check("sw_ie_irq", irq, 8'h08);

    // level held high: acknowledged bit stays clear
    apply(16'h0000, 8'h00, 0, 0, 5'h10, 8'h00);
    check("lvl_set_irq", irq, 8'h18);
    for (int c = 0; c < 4; c++) apply(16'h0000, 8'h00, 0, 0, 5'h10, 8'h00);
    apply(16'h0000, 8'h00, 0, 0, 5'h10, 8'h10);
    for (int c = 0; c < 4; c++) apply(16'h0000, 8'h00, 0, 0, 5'h10, 8'h00);
    apply(16'hff0f, 8'h00, 1, 0, 5'h10, 8'h00);
    check("lvl_if", dout, 8'he8);
    check("lvl_irq", irq, 8'h08);

    // unmapped address
    apply(16'hff10, 8'h00, 1, 0, 5'h00, 8'h00);
    check("dec_dout", dout, 8'hff);
    check("dec_oe", {7'b0, dout_oe}, 8'h00);

    // reset during a strobe: strobe still high afterwards commits
    adr = 16'hffff; din = 8'h03; wr = 1; rd = 0; req = 0; iack = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 0;
    check("rst2_irq", irq, 8'h00);
    apply(16'hffff, 8'h03, 0, 1, 5'h00, 8'h00);
    apply(16'hffff, 8'h00, 1, 0, 5'h00, 8'h00);
    check("rst2_ie", dout, 8'h03);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [15:0] a;
      logic [7:0]  ak;
      case ($urandom_range(3))
        0: a = 16'hff0f;
        1: a = 16'hffff;
        2: a = 16'hff10;
        default: a = 16'($urandom);
      endcase
      ak = 8'h00;
      if ($urandom_range(3) == 0) ak = 8'h01 << $urandom_range(7);
      if ($urandom_range(15) == 0) ak = 8'($urandom);
      apply(a, 8'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), ak);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
